// File: rtl/rr_mem_pkg.sv
// Shared RR row-memory definitions: geometry, FSM state encoding and the
// buffered row payload. Used by the RR reader and writer sides.
package rr_mem_pkg;

  localparam int unsigned ELEMENT_WIDTH = 64;
  localparam int unsigned NO_OF_UNITS   = 8;
  localparam int unsigned ROW_W         = ELEMENT_WIDTH * NO_OF_UNITS;
  localparam int unsigned ADDRESS_WIDTH = 20;
  localparam int unsigned MEM_DEPTH     = 1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rr_state_e;

  typedef struct packed {
    logic             last;
    logic [ROW_W-1:0] row;
  } rr_row_t;

  // Next row address, wrapping from the last memory row back to row 0.
  function automatic logic [ADDRESS_WIDTH-1:0] rr_next_addr(input logic [ADDRESS_WIDTH-1:0] a);
    if (a == ADDRESS_WIDTH'(MEM_DEPTH - 1)) begin
      return '0;
    end
    return a + ADDRESS_WIDTH'(1);
  endfunction

endpackage

// File: rtl/mem_rr_reader_if.sv
// Row stream from the RR reader to a downstream vector unit (valid/ready).
interface mem_rr_reader_if;
  import rr_mem_pkg::*;

  logic [ROW_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (output out_data, output out_valid, output out_last, input  out_ready);
  modport slave  (input  out_data, input  out_valid, input  out_last, output out_ready);

endinterface

// File: rtl/rr_skid_buffer.sv
// Two-entry FIFO of {last, row}. Entry 0 is the head and drives the output
// directly, so the head is always a register.
module rr_skid_buffer
  import rr_mem_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  rr_row_t push_data_i,
  input  logic    pop_i,
  output rr_row_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  logic [1:0] count_q, count_d;
  rr_row_t    ent0_q, ent0_d;
  rr_row_t    ent1_q, ent1_d;
  logic       push_c, pop_c;

  // Entry shuffling for push, pop and simultaneous push+pop.
  always_comb begin
    push_c  = push_i && (count_q != 2'd2);
    pop_c   = pop_i && (count_q != 2'd0);
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    if (push_c && pop_c) begin
      // Only reachable with exactly one entry: new row becomes the head.
      ent0_d = push_data_i;
    end else if (pop_c) begin
      ent0_d  = ent1_q;
      ent1_d  = '0;
      count_d = count_q - 2'd1;
    end else if (push_c) begin
      if (count_q == 2'd0) begin
        ent0_d = push_data_i;
      end else begin
        ent1_d = push_data_i;
      end
      count_d = count_q + 2'd1;
    end
  end

  // Storage registers; reset flushes both entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      count_q <= count_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

  assign head_o  = ent0_q;
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/mem_rr_reader.sv
// RR memory read sequencer: walks [base, base+row_count) modulo MEM_DEPTH,
// captures each row into a 2-entry buffer and streams it over out_if.
// Optional feature macro: RR_READER_CHECKSUM_EN adds a running XOR checksum
// output of all rows handshaken in the current transfer.
module mem_rr_reader
  import rr_mem_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_address,
  input  logic [ADDRESS_WIDTH-1:0] row_count,
  output logic [ADDRESS_WIDTH-1:0] mem_read_address,
  input  logic [ROW_W-1:0]         mem_read_data,
  mem_rr_reader_if.master          out_if,
  output logic                     busy,
  output logic                     done
`ifdef RR_READER_CHECKSUM_EN
  ,
  output logic [ROW_W-1:0]         checksum
`endif
);

  rr_state_e                state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] issued_q, issued_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic    push_c, pop_c, last_row_c, drain_done_c;
  logic    fifo_full, fifo_empty;
  rr_row_t push_row, head_row;

  // Row currently being issued is the final one of the transfer.
  assign last_row_c   = (issued_q == (cnt_q - ADDRESS_WIDTH'(1)));
  assign pop_c        = !fifo_empty && out_if.out_ready;
  // Buffer is empty after this edge (no pushes happen while draining).
  assign drain_done_c = fifo_empty || (pop_c && !fifo_full);
  assign push_row     = {last_row_c, mem_read_data};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && (row_count != '0)) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!fifo_full && last_row_c) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    issued_d = issued_q;
    push_c   = 1'b0;
    done_d   = 1'b0;
    busy_d   = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (row_count != '0) begin
            ptr_d    = base_address;
            cnt_d    = row_count;
            issued_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        push_c = !fifo_full;
        if (push_c) begin
          ptr_d    = rr_next_addr(ptr_q);
          issued_d = issued_q + ADDRESS_WIDTH'(1);
        end
      end
      DRAIN: begin
        done_d = drain_done_c;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      cnt_q    <= '0;
      issued_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  rr_skid_buffer u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_c),
    .push_data_i (push_row),
    .pop_i       (pop_c),
    .head_o      (head_row),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign mem_read_address = ptr_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign out_if.out_data  = head_row.row;
  assign out_if.out_last  = head_row.last;
  assign out_if.out_valid = !fifo_empty;

`ifdef RR_READER_CHECKSUM_EN
  logic [ROW_W-1:0] csum_q, csum_d;

  // Clear on an accepted start, accumulate every handshaken row.
  always_comb begin
    csum_d = csum_q;
    if ((state_q == IDLE) && start) begin
      csum_d = '0;
    end else if (pop_c) begin
      csum_d = csum_q ^ head_row.row;
    end
  end

  // Checksum register; holds its value between transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule
